// File: rtl/arvi_bus_pkg.sv
// Shared types and constants for the ARVI system-bus master.
// Request fields are sized for the widest supported bus and trimmed to XLEN by users.
package arvi_bus_pkg;

  localparam int MAX_PORTS = 8;
  localparam int XLEN_MAX  = 64;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } bus_state_e;

  typedef struct packed {
    logic                    we;
    logic [XLEN_MAX-1:0]     addr;
    logic [XLEN_MAX-1:0]     wdata;
    logic [XLEN_MAX/8-1:0]   byte_en;
  } bus_req_t;

endpackage

// File: rtl/bus_if.sv
// Single-master memory bus link: one request in flight, completed by ack.
interface bus_if #(
  parameter int XLEN = 32
);
  logic              bus_en;
  logic              wr_en;
  logic [XLEN-1:0]   wr_data;
  logic [XLEN-1:0]   addr;
  logic [XLEN/8-1:0] byte_en;
  logic              ack;
  logic [XLEN-1:0]   rd_data;

  modport master (
    output bus_en, wr_en, wr_data, addr, byte_en,
    input  ack, rd_data
  );

  modport slave (
    input  bus_en, wr_en, wr_data, addr, byte_en,
    output ack, rd_data
  );
endinterface

// File: rtl/bus_mux_master_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after rr_ptr, wrapping.
module rr_arbiter #(
  parameter int NPORTS = 2,
  parameter int GW     = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
  input  logic [NPORTS-1:0] req,
  input  logic [GW-1:0]     rr_ptr,
  output logic [NPORTS-1:0] gnt,
  output logic [GW-1:0]     gnt_idx
);

  logic [GW-1:0] w_idx;
  logic          w_hit;
  logic          w_found;

  // scan ports starting at the pointer; only the first hit is granted
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    w_idx   = '0;
    w_hit   = 1'b0;
    w_found = 1'b0;
    for (int i = 0; i < NPORTS; i++) begin
      w_idx      = GW'((int'(rr_ptr) + i) % NPORTS);
      w_hit      = req[w_idx] & ~w_found;
      gnt[w_idx] = w_hit;
      gnt_idx    = w_hit ? w_idx : gnt_idx;
      w_found    = w_found | w_hit;
    end
  end

endmodule

// File: rtl/bus_mux_master.sv
// Round-robin bus master: arbitrates NPORTS requesters onto one bus_if link,
// registers the bus request and steers ack/rd_data back to the granted port.
module bus_mux_master
  import arvi_bus_pkg::*;
#(
  parameter int NPORTS  = 2,
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 0
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic [NPORTS-1:0]                i_req,
  input  logic [NPORTS-1:0]                i_we,
  input  logic [NPORTS-1:0][XLEN-1:0]      i_addr,
  input  logic [NPORTS-1:0][XLEN-1:0]      i_wdata,
  input  logic [NPORTS-1:0][XLEN/8-1:0]    i_byte_en,
  output logic [NPORTS-1:0]                o_ready,
  output logic [NPORTS-1:0]                o_err,
  output logic [XLEN-1:0]                  o_rdata,
  bus_if.master                            bus_m
);

  localparam int            GW         = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int            TW         = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic          TMO_EN     = 1'(TIMEOUT > 0);
  localparam logic [TW-1:0] TCNT_LAST  = TW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam logic [TW-1:0] TCNT_MAX   = {TW{1'b1}};

  bus_state_e          r_state;
  logic [GW-1:0]       r_rr_ptr;
  logic [GW-1:0]       r_grant;
  logic [TW-1:0]       r_tcnt;
  logic                r_bus_en;
  logic                r_wr_en;
  logic [XLEN-1:0]     r_wr_data;
  logic [XLEN-1:0]     r_addr;
  logic [XLEN/8-1:0]   r_byte_en;

  logic [NPORTS-1:0]   w_gnt;
  logic [GW-1:0]       w_gnt_idx;
  logic [GW-1:0]       w_next_ptr;
  logic [NPORTS-1:0]   w_grant_oh;
  bus_req_t            w_sel_req;
  logic                w_unused_sel;
  logic                w_busy;
  logic                w_ack;
  logic                w_tmo;
  logic                w_done;

  rr_arbiter #(
    .NPORTS (NPORTS),
    .GW     (GW)
  ) u_arb (
    .req     (i_req),
    .rr_ptr  (r_rr_ptr),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx)
  );

  // gather the winning port's request; writes are forced word-aligned
  always_comb begin
    w_sel_req                       = '0;
    w_sel_req.we                    = i_we[w_gnt_idx];
    w_sel_req.wdata[XLEN-1:0]       = i_wdata[w_gnt_idx];
    w_sel_req.byte_en[XLEN/8-1:0]   = i_byte_en[w_gnt_idx];
    if (i_we[w_gnt_idx]) begin
      w_sel_req.addr[XLEN-1:0] = {i_addr[w_gnt_idx][XLEN-1:2], 2'b00};
    end else begin
      w_sel_req.addr[XLEN-1:0] = i_addr[w_gnt_idx];
    end
  end

  assign w_unused_sel = ^{w_sel_req.addr, w_sel_req.wdata, w_sel_req.byte_en};
  assign w_next_ptr   = GW'((int'(w_gnt_idx) + 1) % NPORTS);
  assign w_grant_oh   = NPORTS'(1) << r_grant;

  // ack beats a simultaneous timeout; ack is meaningless outside BUSY
  assign w_busy = (r_state == BUSY);
  assign w_ack  = w_busy & bus_m.ack;
  assign w_tmo  = TMO_EN & w_busy & ~bus_m.ack & (r_tcnt == TCNT_LAST);
  assign w_done = w_ack | w_tmo;

  assign o_ready = w_done ? w_grant_oh : '0;
  assign o_err   = w_tmo ? w_grant_oh : '0;
  assign o_rdata = (w_ack & ~r_wr_en) ? bus_m.rd_data : '0;

  assign bus_m.bus_en  = r_bus_en;
  assign bus_m.wr_en   = r_wr_en;
  assign bus_m.wr_data = r_wr_data;
  assign bus_m.addr    = r_addr;
  assign bus_m.byte_en = r_byte_en;

  // FSM, bus request registers, round-robin pointer and timeout counter
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_rr_ptr  <= '0;
      r_grant   <= '0;
      r_tcnt    <= '0;
      r_bus_en  <= 1'b0;
      r_wr_en   <= 1'b0;
      r_wr_data <= '0;
      r_addr    <= '0;
      r_byte_en <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|w_gnt) begin
            r_state   <= BUSY;
            r_grant   <= w_gnt_idx;
            r_rr_ptr  <= w_next_ptr;
            r_tcnt    <= '0;
            r_bus_en  <= 1'b1;
            r_wr_en   <= w_sel_req.we;
            r_wr_data <= w_sel_req.wdata[XLEN-1:0];
            r_addr    <= w_sel_req.addr[XLEN-1:0];
            r_byte_en <= w_sel_req.byte_en[XLEN/8-1:0];
          end
        end
        BUSY: begin
          if (w_done) begin
            r_state  <= IDLE;
            r_bus_en <= 1'b0;
            r_wr_en  <= 1'b0;
          end else if (r_tcnt != TCNT_MAX) begin
            r_tcnt <= r_tcnt + TW'(1);
          end
        end
        default: begin
          r_state  <= IDLE;
          r_bus_en <= 1'b0;
          r_wr_en  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_mux_master.sv
// Scoreboard bench for bus_mux_master (3 ports, 32-bit, timeout of 4 BUSY cycles).
module tb_bus_mux_master;

  localparam int NP  = 3;
  localparam int XL  = 32;
  localparam int TMO = 4;

  typedef struct {
    int          port;
    logic        err;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NP-1:0]             i_req     = '0;
  logic [NP-1:0]             i_we      = '0;
  logic [NP-1:0][XL-1:0]     i_addr    = '0;
  logic [NP-1:0][XL-1:0]     i_wdata   = '0;
  logic [NP-1:0][XL/8-1:0]   i_byte_en = '0;
  logic [NP-1:0]             o_ready;
  logic [NP-1:0]             o_err;
  logic [XL-1:0]             o_rdata;

  bus_if #(.XLEN(XL)) bus ();

  bus_mux_master #(.NPORTS(NP), .XLEN(XL), .TIMEOUT(TMO)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_req     (i_req),
    .i_we      (i_we),
    .i_addr    (i_addr),
    .i_wdata   (i_wdata),
    .i_byte_en (i_byte_en),
    .o_ready   (o_ready),
    .o_err     (o_err),
    .o_rdata   (o_rdata),
    .bus_m     (bus)
  );

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t q[$];
  exp_t m_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // response monitor: every ready/err pulse must match the oldest expectation
  always @(negedge clk) begin
    if (!rst && ((|o_ready) || (|o_err))) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_resp: got ready=%b err=%b want none", o_ready, o_err);
      end else begin
        m_e = q.pop_front();
        chk("ready", 32'(o_ready), 32'(1) << m_e.port);
        chk("err", 32'(o_err), m_e.err ? (32'(1) << m_e.port) : 32'd0);
        chk("rdata", o_rdata, m_e.rdata);
        chk("resp_cycle", cyc, m_e.cyc);
      end
    end
  end

  task automatic do_reset();
    rst      = 1'b1;
    i_req    = '0;
    bus.ack  = 1'b0;
    tick();
    rst = 1'b0;
    chk("rst_bus_en", 32'(bus.bus_en), 32'd0);
    chk("rst_wr_en", 32'(bus.wr_en), 32'd0);
    chk("rst_addr", bus.addr, 32'd0);
    chk("rst_wr_data", bus.wr_data, 32'd0);
    chk("rst_byte_en", 32'(bus.byte_en), 32'd0);
    chk("rst_ready", 32'(o_ready), 32'd0);
    chk("rst_err", 32'(o_err), 32'd0);
    chk("rst_rdata", o_rdata, 32'd0);
  endtask

  // n = BUSY cycle in which ack arrives; n = 0 means never (timeout expected)
  task automatic txn(input int gp, input logic [NP-1:0] mask, input logic we,
                     input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be,
                     input int n, input logic [31:0] rd, input bit keep);
    exp_t        e;
    logic [31:0] ea;
    int          last;
    i_we[gp]      = we;
    i_addr[gp]    = addr;
    i_wdata[gp]   = wd;
    i_byte_en[gp] = be;
    i_req         = i_req | mask;
    ea            = we ? {addr[31:2], 2'b00} : addr;
    last          = (n == 0) ? TMO : n;
    e.port  = gp;
    e.err   = (n == 0);
    e.rdata = ((n == 0) || we) ? 32'd0 : rd;
    e.cyc   = cyc + last;
    q.push_back(e);
    tick();
    chk("bus_en_up", 32'(bus.bus_en), 32'd1);
    chk("addr", bus.addr, ea);
    chk("wr_en", 32'(bus.wr_en), 32'(we));
    chk("byte_en", 32'(bus.byte_en), 32'(be));
    if (we) chk("wr_data", bus.wr_data, wd);
    for (int i = 2; i <= last; i++) begin
      tick();
      chk("bus_en_hold", 32'(bus.bus_en), 32'd1);
    end
    bus.rd_data = rd;
    if (n != 0) bus.ack = 1'b1;
    if (!keep) i_req[gp] = 1'b0;
    tick();
    bus.ack     = 1'b0;
    bus.rd_data = 32'd0;
    chk("bus_en_drop", 32'(bus.bus_en), 32'd0);
    chk("wr_en_drop", 32'(bus.wr_en), 32'd0);
  endtask

  initial begin
    bus.ack     = 1'b0;
    bus.rd_data = 32'd0;
    do_reset();

    // single read, port 0, ack in 3rd BUSY cycle
    txn(0, 3'b001, 1'b0, 32'h0000_0100, 32'h0, 4'hF, 3, 32'hDEAD_BEEF, 1'b0);
    // aligned write from port 1; rd_data must not leak to o_rdata
    txn(1, 3'b010, 1'b1, 32'h0000_0203, 32'h1122_3344, 4'b1000, 1, 32'hFFFF_FFFF, 1'b0);

    // round robin with all ports requesting continuously
    do_reset();
    for (int p = 0; p < NP; p++) begin
      i_we[p]   = 1'b0;
      i_addr[p] = 32'h0000_1000 + 32'(p) * 32'h10;
    end
    for (int k = 0; k < 4; k++) begin
      txn(k % NP, 3'b111, 1'b0, 32'h0000_1000 + 32'(k % NP) * 32'h10, 32'h0, 4'hF,
          1, 32'hA000_0000 + 32'(k), 1'b1);
    end
    i_req = '0;

    // timeout on port 2, then a normal read, then ack colliding with expiry
    txn(2, 3'b100, 1'b0, 32'h0000_0300, 32'h0, 4'hF, 0, 32'h0000_CAFE, 1'b0);
    txn(0, 3'b001, 1'b0, 32'h0000_0040, 32'h0, 4'hF, 1, 32'h55AA_55AA, 1'b0);
    txn(1, 3'b010, 1'b0, 32'h0000_0080, 32'h0, 4'hF, 4, 32'h0BAD_F00D, 1'b0);

    // reset in the middle of a write
    i_we[0] = 1'b1; i_addr[0] = 32'h0000_0500; i_wdata[0] = 32'h9999_8888; i_byte_en[0] = 4'hF;
    i_req   = 3'b001;
    tick();
    chk("mid_bus_en", 32'(bus.bus_en), 32'd1);
    do_reset();
    bus.ack     = 1'b1;
    bus.rd_data = 32'h1234_5678;
    #1;
    chk("late_ack_ready", 32'(o_ready), 32'd0);
    chk("late_ack_rdata", o_rdata, 32'd0);
    tick();
    bus.ack     = 1'b0;
    bus.rd_data = 32'd0;
    chk("late_ack_idle", 32'(bus.bus_en), 32'd0);

    // pointer back at 0: ports 0 and 2 contend, 0 first, then 2
    i_we[2] = 1'b0; i_addr[2] = 32'h0000_3000;
    txn(0, 3'b101, 1'b0, 32'h0000_0400, 32'h0, 4'hF, 1, 32'h0000_0AAA, 1'b0);
    txn(2, 3'b100, 1'b0, 32'h0000_3000, 32'h0, 4'hF, 2, 32'h0000_0BBB, 1'b0);

    tick();
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_mux_master.md
# bus_mux_master

Parametrised bus master that arbitrates NPORTS requesters (e.g. I-fetch, data port, debug/DMA) onto one `bus_if.master` link with registered bus outputs. It grants one transaction at a time using round-robin priority and steers the slave response to the granted requester. An optional timeout turns a missing ack into an error response. It sits between the core's memory-request ports and the system bus, replacing the fixed-priority two-port adapter.

## Interface
- `NPORTS`, 2: number of requester channels; legal values are 1 to 8.
- `XLEN`, 32: address and data width.
- `TIMEOUT`, 0: number of BUSY cycles without ack before an error is raised; 0 disables the timeout.
- `i_clk` input 1: single clock, rising edge.
- `i_rst` input 1: synchronous reset, active-high.
- `i_req` input NPORTS: per-port request; it must be held until that port's `o_ready` pulses.
- `i_we` input NPORTS: per-port write enable; 0 means read.
- `i_addr` input NPORTS×XLEN: per-port byte address.
- `i_wdata` input NPORTS×XLEN: per-port write data.
- `i_byte_en` input NPORTS×XLEN/8: per-port byte enables.
- `o_ready` output NPORTS: one-cycle completion pulse, one-hot.
- `o_err` output NPORTS: one-cycle error pulse, coincident with `o_ready`.
- `o_rdata` output XLEN: read data, valid when any `o_ready` is high.
- `bus_m` interface `bus_if.master`: carries `bus_en`, `wr_en`, `wr_data`, `addr`, `byte_en` (outputs) and `ack`, `rd_data` (inputs).

## Operation
- The FSM has two states, IDLE and BUSY. Reset puts it in IDLE.
- The round-robin pointer `rr_ptr` resets to 0.
- In IDLE, when any `i_req` is high:
  - The arbiter picks the first requesting port at or after `rr_ptr`, wrapping modulo NPORTS.
  - It latches `grant`, `addr`, `wr_en`, `wr_data` and `byte_en` into the bus output registers.
  - It sets `bus_en`=1 and moves to BUSY.
  - `rr_ptr` becomes `(grant+1) mod NPORTS`.
- Write addresses are forced word-aligned: `addr = {i_addr[XLEN-1:2], 2'b00}`. Read addresses pass through unchanged.
- In BUSY, the bus output registers hold their values. The inputs of the granted port are not re-sampled.
- In BUSY, `ack`=1 causes the following in the same cycle:
  - `o_ready[grant]`=1.
  - `o_rdata`=`rd_data` for reads and 0 for writes.
  - At the next edge, `bus_en` and `wr_en` go to 0 and the FSM returns to IDLE.
- Timeout, when TIMEOUT>0:
  - `tcnt` counts BUSY cycles.
  - If `tcnt` reaches TIMEOUT-1 with no ack, `o_ready[grant]`=1 and `o_err[grant]`=1, and `o_rdata`=0.
  - The FSM then returns to IDLE with `bus_en` dropped.
  - `tcnt` clears on entry to BUSY.
- `ack` is ignored while in IDLE.
- If `ack` and timeout expiry happen in the same cycle, `ack` wins and `o_err`=0.
- If the granted port drops `i_req` mid-transaction, the bus transaction still completes and `o_ready` still pulses. Requesters must ignore the unsolicited pulse.
- A port not granted keeps waiting. Starvation is bounded: a waiting port is served after at most NPORTS-1 other transactions.
- When NPORTS=1, the grant is always 0 and the grant register is 1 bit wide.

## Timing
- Reset values: `bus_en`, `wr_en`, `wr_data`, `addr`, `byte_en`, `o_ready`, `o_err` and `o_rdata` are all 0. Reset aborts any transaction in flight, and all of these are 0 after the reset edge.
- Request to bus: `i_req` sampled at edge T gives `bus_en`=1 from T+1.
- Response path: `o_ready`, `o_err` and `o_rdata` are combinational from `ack`/`rd_data` in BUSY, with zero added latency.
- Minimum transaction is 2 cycles: 1 cycle in IDLE, then BUSY with ack in the first BUSY cycle.
- Back-to-back requests: the next arbitration happens in the IDLE cycle after ack. There is one idle bus cycle between transactions, with `bus_en` low for at least 1 cycle.
- `tcnt` width is `$clog2(TIMEOUT+1)`. It saturates and does not wrap.

## Structure
- Package `arvi_bus_pkg` holds:
  - the `bus_state_e` enum {IDLE, BUSY};
  - the `bus_req_t` struct {we, addr, wdata, byte_en};
  - the `MAX_PORTS`=8 constant.
- Sub-module `rr_arbiter` is parametrised by NPORTS:
  - inputs: `req` vector and `rr_ptr`;
  - outputs: one-hot `gnt` and the encoded `gnt_idx`;
  - purely combinational.
- The FSM, output registers, pointer and timeout counter live in `bus_mux_master`.

## Test plan
- **Single read, port 0, NPORTS=2:** `i_addr[0]`=0x100 with ack after 3 BUSY cycles and `rd_data`=0xDEADBEEF.
  - `addr`=0x100 and `bus_en`=1 from T+1.
  - `o_ready[0]` pulses with `o_rdata`=0xDEADBEEF.
  - `bus_en`=0 on the following cycle.
- **Aligned write:** port 1 writes to 0x203 with `byte_en`=4'b1000 and `wdata`=0x11223344.
  - Bus sees `addr`=0x200, `wr_en`=1, `byte_en`=1000.
  - `o_ready[1]` pulses on ack.
- **Round-robin, NPORTS=3:** all ports request continuously, with ack in the first BUSY cycle.
  - Grant order is 0, 1, 2, 0.
  - There is exactly one `bus_en`-low cycle between transactions.
- **Timeout, TIMEOUT=4:** ack is never asserted.
  - `o_ready[g]` and `o_err[g]` pulse in the 4th BUSY cycle, with `o_rdata`=0.
  - FSM returns to IDLE.
  - The next request is served normally.
- **Simultaneous ack and timeout:** ack arrives in the 4th BUSY cycle with TIMEOUT=4. Required: `o_err`=0 and `o_ready`=1.
- **Reset mid-BUSY:** assert `i_rst` for 1 cycle.
  - All bus outputs are 0 after the edge, with FSM in IDLE and `rr_ptr`=0.
  - A late ack is ignored with no `o_ready` pulse.
